instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Reader side of the instruction-memory interface: drives the byte address into the
//   combinational instruction memory, captures the returned 16-bit word and hands it,
//   with its PC, to decode over a valid/ready handshake.
//   Provides a small prefetch buffer, branch/jump redirect with flush, and halt detection.
//   Sits between the instruction memory and the decode stage of the simplified MIPS core.
// PARAMETERS
//   ADDR_W     16        byte-address width; PC advances by 2 per instruction
//   INSTR_W    16        instruction word width
//   DEPTH      2         prefetch FIFO entries (power of 2, >=2)
//   RESET_PC   16'h0000  first fetch address after reset (bit 0 must be 0)
//   HALT_WORD  16'hFFFF  instruction encoding that ends the program
// PORTS
//   Clock           in   1        rising-edge clock
//   Reset           in   1        asynchronous, active-high reset
//   IMemAddress     out  ADDR_W   byte address to instruction memory (= fetch PC)
//   IMemInstruction in   INSTR_W  word returned combinationally for IMemAddress
//   Redirect        in   1        taken branch/jump: flush and refetch
//   RedirectTarget  in   ADDR_W   new fetch byte address; bit 0 ignored (forced 0)
//   InstrValid      out  1        head of FIFO valid for decode
//   InstrReady      in   1        decode accepts head this cycle
//   InstrOut        out  INSTR_W  instruction at FIFO head
//   InstrPC         out  ADDR_W   byte address of InstrOut
//   Halted          out  1        program finished; sticky until Reset
// BEHAVIOUR
//   Reset (async, takes effect immediately, mid-operation included): FetchPC=RESET_PC, FIFO
//     empty, state FETCH; InstrValid=0, InstrOut=0, InstrPC=0, Halted=0.
//   IMemAddress = FetchPC always (combinational from register).
//   States: FETCH, HALT_PEND, HALTED.
//   FETCH: capture when FIFO not full OR pop this cycle (pop = InstrValid & InstrReady).
//     Captured word != HALT_WORD: push {IMemInstruction, FetchPC}; FetchPC += 2.
//     Captured word == HALT_WORD: not pushed; FetchPC holds; -> HALT_PEND.
//     Full and no pop: no capture, FetchPC holds.
//   HALT_PEND: no fetch; FIFO drains normally; when FIFO becomes empty -> HALTED.
//   HALTED: Halted=1, InstrValid=0, no fetch; Redirect ignored; exit only via Reset.
//   Latency: word at FetchPC captured at edge N appears with InstrValid=1 after edge N
//     (1 cycle from address to valid). Continuous ready => 1 instruction/cycle.
//   Pop and push in same cycle allowed when full; count unchanged.
//   Redirect (FETCH or HALT_PEND): at the edge, FIFO flushed, FetchPC={RedirectTarget[15:1],0},
//     state -> FETCH; nothing captured that cycle. A pop coincident with Redirect is void:
//     the redirect source must not count it. First redirected word valid 2 edges later.
//   Wrap-around: FetchPC 16'hFFFE + 2 -> 16'h0000, no flag.
//   InstrOut/InstrPC hold head entry while InstrValid=1 & InstrReady=0 (stable under backpressure).
//   Width rule: FIFO count DEPTH+1 states; pointers wrap modulo DEPTH.
// TESTING
//   Program 0x710F,0x7207,0x26C0,0x16C0,0x3980,0x06C0,0x4740,0x710F,0x65FF,0xFFFF at 0..18,
//     InstrReady=1 -> 9 handshakes, InstrPC 0,2,..16 in order; halt word never valid;
//     Halted=1 the cycle after the 9th pop.
//   Same program, InstrReady=0 -> InstrValid=1, InstrOut=0x710F stable; IMemAddress
//     stops at 4 (DEPTH=2); release ready -> 0x7207 at PC 2 next, no loss/duplication.
//   Redirect=1, RedirectTarget=16'h0009 mid-stream -> FIFO flushed; next valid InstrPC=0x0008,
//     InstrOut=0x710F; coincident pop not counted.
//   RESET_PC=16'hFFFE, mem[FFFE]=0x1111, mem[0]=0x2222 -> InstrPC FFFE then 0000.
//   Halt word reached with 2 entries buffered, Redirect to 0 during HALT_PEND -> Halted stays 0,
//     refetch from PC 0.
//   Reset asserted asynchronously between edges while InstrValid=1 -> InstrValid=0, Halted=0,
//     IMemAddress=RESET_PC immediately; first valid 1 edge after Reset falls.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the fetch PC to a combinational instruction memory,
// buffers returned words in a small prefetch FIFO, and handles redirect/flush and halt.
module instruction_fetch_unit #(
  parameter int unsigned         ADDR_W    = 16,
  parameter int unsigned         INSTR_W   = 16,
  parameter int unsigned         DEPTH     = 2,
  parameter logic [ADDR_W-1:0]   RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0]  HALT_WORD = 16'hFFFF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_target_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               halted_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_FETCH     = 2'd0;
  localparam logic [1:0] ST_HALT_PEND = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

  logic pop;
  logic pop_eff;
  logic push;
  logic flush;

  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = instr_mem_q[rd_ptr_q];
  assign instr_pc_o    = pc_mem_q[rd_ptr_q];
  assign halted_o      = halted_q;

  assign pop = valid_q & instr_ready_i;

  // Next-state: fetch/capture decision, redirect flush, FIFO bookkeeping, halt drain
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    push     = 1'b0;
    flush    = 1'b0;
    pop_eff  = 1'b0;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = 1'b0;
    halted_d = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (redirect_i) begin
          flush = 1'b1;
          pc_d  = redirect_target_i & ~ADDR_W'(1);
        end else if ((cnt_q < CNT_W'(DEPTH)) || pop) begin
          if (imem_instr_i == HALT_WORD) begin
            state_d = ST_HALT_PEND;
          end else begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(2);
          end
        end
      end
      ST_HALT_PEND: begin
        if (redirect_i) begin
          flush   = 1'b1;
          pc_d    = redirect_target_i & ~ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // A pop coincident with a flush never reaches decode
    pop_eff = pop & ~flush;

    if (flush) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop_eff);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
    end

    if ((state_d == ST_HALT_PEND) && (cnt_d == '0)) begin
      state_d = ST_HALTED;
    end

    valid_d  = (cnt_d != '0) && (state_d != ST_HALTED);
    halted_d = (state_d == ST_HALTED);
  end

  // State, pointer and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Prefetch storage; cleared on reset so the head reads as zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_instr_i;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table-driven backpressure vectors,
// a handshake scoreboard, and directed redirect/halt/wrap/reset sequences.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic        ready;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] addr;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        valid;
  logic        ready;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        halted;

  logic [15:0] imem_addr2;
  logic [15:0] imem_instr2;
  logic        redirect2;
  logic [15:0] redirect_target2;
  logic        valid2;
  logic        ready2;
  logic [15:0] instr2;
  logic [15:0] instr_pc2;
  logic        halted2;

  logic [15:0] mem  [32768];
  logic [15:0] mem2 [32768];

  int   checks;
  int   errors;
  int   hs_count;
  int   hs_base;
  exp_t exp_q [$];
  vec_t vecs [8];

  assign imem_instr  = mem[imem_addr[15:1]];
  assign imem_instr2 = mem2[imem_addr2[15:1]];

  instruction_fetch_unit dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .imem_addr_o       (imem_addr),
    .imem_instr_i      (imem_instr),
    .redirect_i        (redirect),
    .redirect_target_i (redirect_target),
    .instr_valid_o     (valid),
    .instr_ready_i     (ready),
    .instr_o           (instr),
    .instr_pc_o        (instr_pc),
    .halted_o          (halted)
  );

  instruction_fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
    .clk_i             (clk),
    .rst_i             (rst),
    .imem_addr_o       (imem_addr2),
    .imem_instr_i      (imem_instr2),
    .redirect_i        (redirect2),
    .redirect_target_i (redirect_target2),
    .instr_valid_o     (valid2),
    .instr_ready_i     (ready2),
    .instr_o           (instr2),
    .instr_pc_o        (instr_pc2),
    .halted_o          (halted2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive/check point: 2 time units after the falling edge
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [15:0] i, input logic [15:0] p);
    exp_q.push_back('{instr: i, pc: p});
  endtask

  task automatic load_main_prog(input logic [15:0] word_at_8);
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = 16'h710F; mem[1] = 16'h7207; mem[2] = 16'h26C0; mem[3] = 16'h16C0;
    mem[4] = word_at_8; mem[5] = 16'h06C0; mem[6] = 16'h4740; mem[7] = 16'h710F;
    mem[8] = 16'h65FF; mem[9] = 16'hFFFF;
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect = 1'b0;
    ready = 1'b0;
    exp_q.delete();
    tick();
    chk("rst_valid", 16'(valid), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    tick();
    ready = rdy;
    rst = 1'b0;
    hs_base = hs_count;
  endtask

  task automatic wait_hs(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (hs_count - hs_base >= n) break;
      tick();
    end
    chk("hs_reached", 16'(hs_count - hs_base), 16'(n));
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      tick();
    end
    chk("halted_reached", 16'(halted), 16'd1);
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && !redirect && valid && ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got %h@%h expected none", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", instr, e.instr);
          chk("sb_pc", instr_pc, e.pc);
        end
      end
    end
  end

  initial begin
    clk = 1'b0; rst = 1'b1; redirect = 1'b0; redirect_target = 16'h0000; ready = 1'b0;
    redirect2 = 1'b0; redirect_target2 = 16'h0000; ready2 = 1'b1;
    checks = 0; errors = 0; hs_count = 0; hs_base = 0;
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'h0000;
      mem2[i] = 16'h0000;
    end
    mem2[16'h7FFF] = 16'h1111; mem2[0] = 16'h2222; mem2[1] = 16'hFFFF;

    vecs[0] = '{1'b0, 1'b1, 16'h710F, 16'h0000, 16'h0002};
    vecs[1] = '{1'b0, 1'b1, 16'h710F, 16'h0000, 16'h0004};
    vecs[2] = '{1'b0, 1'b1, 16'h710F, 16'h0000, 16'h0004};
    vecs[3] = '{1'b0, 1'b1, 16'h710F, 16'h0000, 16'h0004};
    vecs[4] = '{1'b1, 1'b1, 16'h7207, 16'h0002, 16'h0006};
    vecs[5] = '{1'b1, 1'b1, 16'h26C0, 16'h0004, 16'h0008};
    vecs[6] = '{1'b0, 1'b1, 16'h26C0, 16'h0004, 16'h0008};
    vecs[7] = '{1'b1, 1'b1, 16'h16C0, 16'h0006, 16'h000A};

    // Wrap-around instance and reset output values
    load_main_prog(16'h3980);
    rst = 1'b1;
    tick();
    chk("rst_out", instr, 16'h0000);
    chk("rst_pc", instr_pc, 16'h0000);
    chk("wrap_rst_addr", imem_addr2, 16'hFFFE);
    do_reset(1'b0);
    tick();
    chk("wrap_valid0", 16'(valid2), 16'd1);
    chk("wrap_out0", instr2, 16'h1111);
    chk("wrap_pc0", instr_pc2, 16'hFFFE);
    chk("wrap_addr0", imem_addr2, 16'h0000);
    tick();
    chk("wrap_out1", instr2, 16'h2222);
    chk("wrap_pc1", instr_pc2, 16'h0000);
    tick();
    chk("wrap_halted", 16'(halted2), 16'd1);
    chk("wrap_valid_end", 16'(valid2), 16'd0);

    // Backpressure table, then drain to halt
    do_reset(1'b0);
    push_exp(16'h710F, 16'h0000); push_exp(16'h7207, 16'h0002); push_exp(16'h26C0, 16'h0004);
    for (int i = 0; i < 8; i++) begin
      ready = vecs[i].ready;
      tick();
      chk("vec_valid", 16'(valid), 16'(vecs[i].valid));
      chk("vec_instr", instr, vecs[i].instr);
      chk("vec_pc", instr_pc, vecs[i].pc);
      chk("vec_addr", imem_addr, vecs[i].addr);
    end
    push_exp(16'h16C0, 16'h0006); push_exp(16'h3980, 16'h0008); push_exp(16'h06C0, 16'h000A);
    push_exp(16'h4740, 16'h000C); push_exp(16'h710F, 16'h000E); push_exp(16'h65FF, 16'h0010);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hs_count - hs_base >= 9) break;
    end
    chk("run_hs", 16'(hs_count - hs_base), 16'd9);
    chk("run_halted", 16'(halted), 16'd1);
    chk("run_valid_end", 16'(valid), 16'd0);
    chk("run_addr_end", imem_addr, 16'h0012);
    chk("run_sb_empty", 16'(exp_q.size()), 16'd0);

    // Redirect mid-stream with a coincident pop
    load_main_prog(16'h710F);
    do_reset(1'b1);
    push_exp(16'h710F, 16'h0000); push_exp(16'h7207, 16'h0002); push_exp(16'h26C0, 16'h0004);
    wait_hs(2, 20);
    exp_q.delete();
    push_exp(16'h710F, 16'h0008); push_exp(16'h06C0, 16'h000A); push_exp(16'h4740, 16'h000C);
    push_exp(16'h710F, 16'h000E); push_exp(16'h65FF, 16'h0010);
    redirect = 1'b1; redirect_target = 16'h0009;
    tick();
    redirect = 1'b0;
    chk("redir_valid", 16'(valid), 16'd0);
    chk("redir_addr", imem_addr, 16'h0008);
    tick();
    chk("redir_first_valid", 16'(valid), 16'd1);
    chk("redir_first_instr", instr, 16'h710F);
    chk("redir_first_pc", instr_pc, 16'h0008);
    wait_halted(40);
    chk("redir_hs", 16'(hs_count - hs_base), 16'd7);
    chk("redir_sb_empty", 16'(exp_q.size()), 16'd0);

    // Halt pending with buffered entries, redirect back to 0
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = 16'hAAAA; mem[1] = 16'hBBBB; mem[2] = 16'hFFFF;
    do_reset(1'b0);
    push_exp(16'hAAAA, 16'h0000); push_exp(16'hBBBB, 16'h0002);
    tick(); tick(); tick();
    chk("hp_full_addr", imem_addr, 16'h0004);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("hp_halted", 16'(halted), 16'd0);
    chk("hp_head", instr, 16'hBBBB);
    tick(); tick();
    chk("hp_hold_halted", 16'(halted), 16'd0);
    chk("hp_hold_valid", 16'(valid), 16'd1);
    chk("hp_hold_addr", imem_addr, 16'h0004);
    exp_q.delete();
    push_exp(16'hAAAA, 16'h0000); push_exp(16'hBBBB, 16'h0002);
    redirect = 1'b1; redirect_target = 16'h0000;
    tick();
    redirect = 1'b0;
    chk("hp_redir_valid", 16'(valid), 16'd0);
    chk("hp_redir_addr", imem_addr, 16'h0000);
    chk("hp_redir_halted", 16'(halted), 16'd0);
    ready = 1'b1;
    wait_halted(20);
    chk("hp_hs", 16'(hs_count - hs_base), 16'd3);
    redirect = 1'b1; redirect_target = 16'h0020;
    tick();
    redirect = 1'b0;
    tick();
    chk("halted_ignores_redir", 16'(halted), 16'd1);
    chk("halted_valid", 16'(valid), 16'd0);
    chk("halted_addr", imem_addr, 16'h0004);

    // Asynchronous reset between edges
    rst = 1'b1;
    #1;
    chk("async_halted", 16'(halted), 16'd0);
    chk("async_addr0", imem_addr, 16'h0000);
    exp_q.delete();
    tick();
    ready = 1'b0;
    rst = 1'b0;
    tick();
    chk("pre_async_valid", 16'(valid), 16'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_valid", 16'(valid), 16'd0);
    chk("async_out", instr, 16'h0000);
    chk("async_addr1", imem_addr, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    chk("post_async_valid", 16'(valid), 16'd1);
    chk("post_async_instr", instr, 16'hAAAA);
    chk("post_async_pc", instr_pc, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
